// File: rtl/div_period_meter.sv
// div_period_meter: receive-side checker for a clk-synchronous divided clock.
// Measures the rise-to-rise period and the high time of div_in in clk cycles.
// Declares lock after LOCK_CNT consecutive periods match EXP_PERIOD/EXP_HIGH.
// Flags a mismatched measurement (err) and a stuck divider (ovf, sticky).
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   en         measurement enable; low clears back to IDLE synchronously
//   div_in     divided clock under test
//   period_out last measured period
//   high_out   last measured high time
//   meas_valid 1-cycle pulse when period_out/high_out update
//   locked     LOCK_CNT consecutive matching periods seen
//   err        1-cycle pulse with meas_valid on a mismatching measurement
//   ovf        sticky, period counter saturated
module div_period_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXP_PERIOD = 2,
  parameter int unsigned EXP_HIGH   = 1,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             ovf
);

  localparam int unsigned MCNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              div_q;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              meas_valid_q, meas_valid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic              rise;
  logic              match;
  logic [31:0]       mcnt_inc;

  // Rising edge of div_in relative to last cycle's sample.
  assign rise     = div_in & ~div_q;
  assign match    = (pcnt_q == CNT_W'(EXP_PERIOD)) && (hcnt_q == CNT_W'(EXP_HIGH));
  assign mcnt_inc = 32'(mcnt_q) + 32'd1;

  // State register and all output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      div_q        <= 1'b0;
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      mcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_in;
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      mcnt_q       <= mcnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  // Next-state and measurement logic; en low overrides rise and saturation.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    hcnt_d       = hcnt_q;
    mcnt_d       = mcnt_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    err_d        = 1'b0;
    ovf_d        = ovf_q;

    if (!en) begin
      state_d  = ST_IDLE;
      pcnt_d   = '0;
      hcnt_d   = '0;
      mcnt_d   = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          // First rise only aligns the counters; it closes no period.
          if (rise) begin
            state_d = ST_MEASURE;
            pcnt_d  = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_d     = pcnt_q;
            high_d       = hcnt_q;
            meas_valid_d = 1'b1;
            pcnt_d       = CNT_W'(1);
            hcnt_d       = CNT_W'(1);
            if (match) begin
              mcnt_d   = (mcnt_inc >= LOCK_CNT) ? MCNT_W'(LOCK_CNT) : MCNT_W'(mcnt_inc);
              locked_d = (mcnt_inc >= LOCK_CNT);
            end else begin
              mcnt_d   = '0;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
          end else if (pcnt_q == CNT_MAX) begin
            // Divider stuck: drop lock and wait for a fresh rise.
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            state_d  = ST_SYNC;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            if (div_in && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_div_period_meter.sv
// Bench for div_period_meter: a default instance and a CNT_W=4 instance share
// stimulus; both are compared every cycle against a timestamp-based model.
module tb_div_period_meter;

  localparam int EP   = 2;
  localparam int EH   = 1;
  localparam int LOCK = 4;
  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_MEAS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic div_in = 1'b0;

  logic [15:0] per16, hi16;
  logic        mv16, lk16, er16, ov16;
  logic [3:0]  per4, hi4;
  logic        mv4, lk4, er4, ov4;

  int checks = 0;
  int failures = 0;

  div_period_meter dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in),
    .period_out(per16), .high_out(hi16), .meas_valid(mv16),
    .locked(lk16), .err(er16), .ovf(ov16)
  );

  div_period_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in),
    .period_out(per4), .high_out(hi4), .meas_valid(mv4),
    .locked(lk4), .err(er4), .ovf(ov4)
  );

  always #5 clk = ~clk;

  // Reference: remembers the cycle of the last rise and counts high samples
  // since then; a period is the distance between two rises.
  typedef struct {
    int mode;
    int last;
    int highs;
    int good;
    bit lk;
    bit mv;
    bit er;
    bit ov;
    int per;
    int hi;
  } mdl_t;

  mdl_t m16 = '{default: 0};
  mdl_t m4  = '{default: 0};
  logic prev_d = 1'b0;
  logic rise_m;
  int   now = 0;

  function automatic mdl_t step(input mdl_t mi, input logic e, input logic d,
                                input logic r, input int t, input int maxv);
    mdl_t m;
    int elapsed;
    m = mi;
    m.mv = 1'b0;
    m.er = 1'b0;
    if (!e) begin
      m.mode = M_IDLE; m.good = 0; m.lk = 1'b0; m.ov = 1'b0;
      return m;
    end
    case (m.mode)
      M_IDLE: m.mode = M_SYNC;
      M_SYNC: if (r) begin m.mode = M_MEAS; m.last = t; m.highs = 1; end
      default: begin
        elapsed = t - m.last;
        if (r) begin
          m.per = elapsed; m.hi = m.highs; m.mv = 1'b1;
          if (elapsed == EP && m.highs == EH) begin
            m.good = (m.good + 1 > LOCK) ? LOCK : m.good + 1;
            m.lk = (m.good >= LOCK);
          end else begin
            m.good = 0; m.lk = 1'b0; m.er = 1'b1;
          end
          m.last = t; m.highs = 1;
        end else if (elapsed == maxv) begin
          m.ov = 1'b1; m.lk = 1'b0; m.good = 0; m.mode = M_SYNC;
        end else if (d) begin
          m.highs++;
        end
      end
    endcase
    return m;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m16 = '{default: 0};
      m4 = '{default: 0};
      prev_d = 1'b0;
      now = 0;
    end else begin
      rise_m = div_in & ~prev_d;
      m16 = step(m16, en, div_in, rise_m, now, 65535);
      m4 = step(m4, en, div_in, rise_m, now, 15);
      prev_d = div_in;
      now++;
    end
  end

  logic [35:0] act16, exp16;
  logic [11:0] act4, exp4;
  assign act16 = {mv16, lk16, er16, ov16, per16, hi16};
  assign exp16 = {m16.mv, m16.lk, m16.er, m16.ov, 16'(m16.per), 16'(m16.hi)};
  assign act4  = {mv4, lk4, er4, ov4, per4, hi4};
  assign exp4  = {m4.mv, m4.lk, m4.er, m4.ov, 4'(m4.per), 4'(m4.hi)};

  // Drive one div_in sample, then settle just past the capturing edge.
  task automatic tick(input logic d);
    div_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; div_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (act16 !== 36'h0) begin failures++; $display("FAIL reset16 act=%h exp=0", act16); end
    checks++; if (act4 !== 12'h0) begin failures++; $display("FAIL reset4 act=%h exp=0", act4); end
    rst = 1'b1;
  endtask

  task automatic test_divby2();
    int nmv = 0, nerr = 0, lock_at = 0;
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(i % 2 == 0);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL divby2_16 t=%0t act=%h exp=%h", $time, act16, exp16); end
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL divby2_4 t=%0t act=%h exp=%h", $time, act4, exp4); end
      if (mv16) nmv++;
      if (er16) nerr++;
      if (lk16 && lock_at == 0) lock_at = nmv;
    end
    checks++; if (lock_at !== 4) begin failures++; $display("FAIL divby2_lock_at act=%0d exp=4", lock_at); end
    checks++; if (nerr !== 0) begin failures++; $display("FAIL divby2_err act=%0d exp=0", nerr); end
    checks++; if (per16 !== 16'd2 || hi16 !== 16'd1) begin failures++; $display("FAIL divby2_meas act=%0d/%0d exp=2/1", per16, hi16); end
  endtask

  task automatic test_mismatch();
    int nmv = 0, nerr = 0, nlk = 0;
    en = 1'b0;
    tick(1'b0);
    en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick((i % 6) < 3);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL mismatch16 t=%0t act=%h exp=%h", $time, act16, exp16); end
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL mismatch4 t=%0t act=%h exp=%h", $time, act4, exp4); end
      if (mv16) nmv++;
      if (mv16 && er16) nerr++;
      if (lk16) nlk++;
    end
    checks++; if (nmv !== 6) begin failures++; $display("FAIL mismatch_count act=%0d exp=6", nmv); end
    checks++; if (nerr !== nmv) begin failures++; $display("FAIL mismatch_err act=%0d exp=%0d", nerr, nmv); end
    checks++; if (nlk !== 0) begin failures++; $display("FAIL mismatch_lock act=%0d exp=0", nlk); end
    checks++; if (per16 !== 16'd6 || hi16 !== 16'd3) begin failures++; $display("FAIL mismatch_meas act=%0d/%0d exp=6/3", per16, hi16); end
  endtask

  task automatic test_glitch();
    logic stim[$];
    int nerr = 0, err_unlocked = 0, relock_mv = 0, after = 0;
    for (int i = 0; i < 16; i++) stim.push_back(i % 2 == 0);
    for (int i = 0; i < 16; i++) begin
      tick(stim[i]);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL glitch_pre16 t=%0t act=%h exp=%h", $time, act16, exp16); end
    end
    checks++; if (lk16 !== 1'b1) begin failures++; $display("FAIL glitch_prelock act=%b exp=1", lk16); end
    stim.delete();
    stim.push_back(1'b1); stim.push_back(1'b1); stim.push_back(1'b0);
    for (int i = 0; i < 20; i++) stim.push_back(i % 2 == 0);
    for (int i = 0; i < stim.size(); i++) begin
      tick(stim[i]);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL glitch16 t=%0t act=%h exp=%h", $time, act16, exp16); end
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL glitch4 t=%0t act=%h exp=%h", $time, act4, exp4); end
      if (er16) begin nerr++; if (mv16 && !lk16) err_unlocked++; after = 1; end
      else if (after == 1 && mv16) begin relock_mv++; if (lk16) after = 2; end
    end
    checks++; if (nerr !== 1 || err_unlocked !== 1) begin failures++; $display("FAIL glitch_err act=%0d/%0d exp=1/1", nerr, err_unlocked); end
    checks++; if (relock_mv !== 4 || after !== 2) begin failures++; $display("FAIL glitch_relock act=%0d exp=4", relock_mv); end
  endtask

  task automatic test_ovf();
    int rises = 0, lock_rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(i % 2 == 0);
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL ovf_pre4 t=%0t act=%h exp=%h", $time, act4, exp4); end
    end
    checks++; if (lk4 !== 1'b1) begin failures++; $display("FAIL ovf_prelock act=%b exp=1", lk4); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL ovf_hold16 t=%0t act=%h exp=%h", $time, act16, exp16); end
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL ovf_hold4 t=%0t act=%h exp=%h", $time, act4, exp4); end
    end
    checks++; if (ov4 !== 1'b1 || lk4 !== 1'b0 || ov16 !== 1'b0) begin failures++; $display("FAIL ovf_set act=%b%b%b exp=100", ov4, lk4, ov16); end
    for (int i = 0; i < 16; i++) begin
      tick(i % 2 == 0);
      if ((i % 2 == 0) && !prev) rises++;
      prev = (i % 2 == 0);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL ovf_resume16 t=%0t act=%h exp=%h", $time, act16, exp16); end
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL ovf_resume4 t=%0t act=%h exp=%h", $time, act4, exp4); end
      if (lk4 && lock_rises == 0) lock_rises = rises;
    end
    checks++; if (lock_rises !== 5) begin failures++; $display("FAIL ovf_relock_rises act=%0d exp=5", lock_rises); end
    checks++; if (ov4 !== 1'b1) begin failures++; $display("FAIL ovf_sticky act=%b exp=1", ov4); end
  endtask

  task automatic test_rst_mid();
    int rises = 0, first_mv = 0;
    logic prev = 1'b1;
    tick(1'b1);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (act16 !== 36'h0) begin failures++; $display("FAIL rstmid16 act=%h exp=0", act16); end
    checks++; if (act4 !== 12'h0) begin failures++; $display("FAIL rstmid4 act=%h exp=0", act4); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(i % 2 == 1);
      if ((i % 2 == 1) && !prev) rises++;
      prev = (i % 2 == 1);
      checks++; if (act16 !== exp16) begin failures++; $display("FAIL rstmid_run16 t=%0t act=%h exp=%h", $time, act16, exp16); end
      if (mv16 && first_mv == 0) first_mv = rises;
    end
    checks++; if (first_mv !== 2) begin failures++; $display("FAIL rstmid_first_mv act=%0d exp=2", first_mv); end
  endtask

  task automatic test_en_clear();
    logic [3:0] sp4, sh4;
    logic [15:0] sp16, sh16;
    for (int i = 0; i < 20; i++) tick(1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(i % 2 == 0);
      checks++; if (act4 !== exp4) begin failures++; $display("FAIL enclr_pre4 t=%0t act=%h exp=%h", $time, act4, exp4); end
    end
    checks++; if (lk4 !== 1'b1 || ov4 !== 1'b1) begin failures++; $display("FAIL enclr_pre act=%b%b exp=11", lk4, ov4); end
    sp4 = per4; sh4 = hi4; sp16 = per16; sh16 = hi16;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(i % 2 == 0);
      checks++; if ({lk4, ov4, mv4, er4} !== 4'b0000) begin failures++; $display("FAIL enclr_flags4 act=%b%b%b%b exp=0000", lk4, ov4, mv4, er4); end
      checks++; if (lk16 !== 1'b0 || mv16 !== 1'b0) begin failures++; $display("FAIL enclr_flags16 act=%b%b exp=00", lk16, mv16); end
      checks++; if (per4 !== sp4 || hi4 !== sh4 || per16 !== sp16 || hi16 !== sh16) begin
        failures++; $display("FAIL enclr_hold act=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", per4, hi4, per16, hi16, sp4, sh4, sp16, sh16);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_random();
    int unsigned sel, hi_n, lo_n, reps;
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin hi_n = 1; lo_n = 1; end
      else if (sel == 9) begin hi_n = 1; lo_n = $urandom_range(14, 18); end
      else begin hi_n = $urandom_range(1, 4); lo_n = $urandom_range(1, 4); end
      reps = $urandom_range(1, 4);
      en = ($urandom_range(0, 9) != 0);
      for (int r = 0; r < int'(reps); r++) begin
        for (int c = 0; c < int'(hi_n + lo_n); c++) begin
          tick(c < int'(hi_n));
          checks++; if (act16 !== exp16) begin failures++; $display("FAIL random16 t=%0t act=%h exp=%h", $time, act16, exp16); end
          checks++; if (act4 !== exp4) begin failures++; $display("FAIL random4 t=%0t act=%h exp=%h", $time, act4, exp4); end
        end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_divby2();
    test_mismatch();
    test_glitch();
    test_ovf();
    test_rst_mid();
    test_en_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
